// File: rtl/i2s_dac_tx.sv
// I2S transmitter: serializes one stereo sample per frame, MSB first with the
// standard one-bit delay, and provides a frame-start tick for upstream logic.
module i2s_dac_tx #(
  parameter int DAC_OUTPUT_WIDTH = 24,
  parameter int BCLK_DIV         = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_valid,
  input  logic [DAC_OUTPUT_WIDTH-1:0] sample_l,
  input  logic [DAC_OUTPUT_WIDTH-1:0] sample_r,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_sdata,
  output logic                        frame_start,
  output logic                        overrun,
  output logic                        underrun
);

  localparam int W  = DAC_OUTPUT_WIDTH;
  localparam int B  = $clog2(BCLK_DIV);
  localparam int PW = B + 6;
  localparam logic [PW-1:0] P_LAST = {PW{1'b1}};
  localparam logic [4:0]    W5     = 5'(W);

  logic [PW-1:0] p_q, p_d;
  logic          started_q, started_d;
  logic [W-1:0]  hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [W-1:0]  tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic          pending_q, pending_d;
  logic          bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic          fs_q, fs_d, ov_q, ov_d, ur_q, ur_d;

  logic          load_s;
  logic [4:0]    slot_s;
  logic [4:0]    bit_idx_s;
  logic [W-1:0]  word_s;
  logic [W-1:0]  shifted_s;

  // Position counter, sample holding/transmit registers and output decode.
  always_comb begin
    p_d       = p_q;
    started_d = 1'b1;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    tx_l_d    = tx_l_q;
    tx_r_d    = tx_r_q;
    pending_d = pending_q;
    sdata_d   = 1'b0;

    // The first edge after reset parks on position 0 so frame 0 starts cleanly.
    load_s = started_q && (p_q == P_LAST);
    if (started_q) begin
      p_d = p_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      p_d = '0;
    end

    if (load_s) begin
      if (sample_valid) begin
        tx_l_d   = sample_l;
        tx_r_d   = sample_r;
        hold_l_d = sample_l;
        hold_r_d = sample_r;
      end else begin
        tx_l_d = hold_l_q;
        tx_r_d = hold_r_q;
      end
      pending_d = 1'b0;
    end else if (sample_valid) begin
      hold_l_d  = sample_l;
      hold_r_d  = sample_r;
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    // Outputs describe the position being entered, so they line up with p_q.
    slot_s    = p_d[B+4:B];
    bit_idx_s = W5 - slot_s;
    word_s    = p_d[B+5] ? tx_r_q : tx_l_q;
    shifted_s = word_s >> bit_idx_s;
    if ((slot_s != 5'd0) && (slot_s <= W5)) begin
      sdata_d = shifted_s[0];
    end else begin
      sdata_d = 1'b0;
    end

    lrclk_d = p_d[B+5];
    bclk_d  = p_d[B-1];
    fs_d    = (p_d == '0);
    ov_d    = sample_valid && pending_q && !load_s;
    ur_d    = load_s && !pending_q && !sample_valid;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q       <= '0;
      started_q <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      tx_l_q    <= '0;
      tx_r_q    <= '0;
      pending_q <= 1'b0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      fs_q      <= 1'b0;
      ov_q      <= 1'b0;
      ur_q      <= 1'b0;
    end else begin
      p_q       <= p_d;
      started_q <= started_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      tx_l_q    <= tx_l_d;
      tx_r_q    <= tx_r_d;
      pending_q <= pending_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      fs_q      <= fs_d;
      ov_q      <= ov_d;
      ur_q      <= ur_d;
    end
  end

  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = lrclk_q;
  assign i2s_sdata   = sdata_q;
  assign frame_start = fs_q;
  assign overrun     = ov_q;
  assign underrun    = ur_q;

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Serializes left/right DAC samples into a standard I2S stream for the SSM2603 codec at the OPL3 sample rate. Sits after the channel mixer and DAC left-shift stage. It accepts one stereo sample per sample period from the mixer and generates BCLK, LRCLK and SDATA from the 12.727 MHz master clock (256 clocks per frame, about 49.7148 kHz). It also returns a frame-start strobe that upstream logic uses as its sample tick.

## Interface
- `DAC_OUTPUT_WIDTH`, default 24: sample width in bits. Legal range 2..31.
- `BCLK_DIV`, default 4: clk cycles per BCLK period. Must be a power of two, ≥2. Frame length is 64·BCLK_DIV clocks (256 by default, equal to CLK_DIV_COUNT).
- `clk` in, 1: master clock; also forwarded externally as MCLK.
- `reset` in, 1: asynchronous, active-high.
- `sample_valid` in, 1: one-cycle strobe; `sample_l`/`sample_r` are valid this cycle.
- `sample_l` in, DAC_OUTPUT_WIDTH: signed two's complement left sample.
- `sample_r` in, DAC_OUTPUT_WIDTH: signed two's complement right sample.
- `i2s_bclk` out, 1: bit clock.
- `i2s_lrclk` out, 1: word select; 0 = left, 1 = right.
- `i2s_sdata` out, 1: serial data, MSB first.
- `frame_start` out, 1: one-cycle pulse at frame position 0.
- `overrun` out, 1: one-cycle pulse when a sample is overwritten before transmission.
- `underrun` out, 1: one-cycle pulse when a frame load finds no new sample.

## Operation
- **Frame position counter** p:
  - Free-running, 0..64·BCLK_DIV−1, incrementing every clk.
  - Wraps to 0.
- **Definitions**, with B = log2(BCLK_DIV):
  - Half-frame h = p[B+5].
  - Slot s = p[B+4:B] (0..31).
  - bclk phase = p[B−1].
- **Outputs:** all outputs are registered. In the cycle where the position is p:
  - `i2s_lrclk` = h.
  - `i2s_bclk` = p[B−1]: low for the first half of each slot, high for the second half.
  - `i2s_sdata`:
    - slot 0 (I2S one-bit delay) → 0;
    - slots 1..W → word bit W−s, where W = DAC_OUTPUT_WIDTH;
    - slots W+1..31 → 0.
  - The word is the left shift register when h=0 and the right shift register when h=1.
  - SDATA therefore changes only on the BCLK falling edge (slot boundary) and is stable on the rising edge.
- **Holding register** (hold_l, hold_r, pending flag):
  - `sample_valid` writes hold_l/hold_r and sets pending.
  - If `sample_valid` arrives while pending=1 and no load occurs in that cycle → `overrun` pulse; the newer sample wins.
- **Frame load**, on the edge where p goes from the last position to 0:
  - tx_l/tx_r load from the holding register, and pending clears.
  - If `sample_valid` is high in that same cycle, the incoming sample bypasses into tx_l/tx_r directly. Pending stays clear and there is no overrun.
  - If pending=0 and `sample_valid`=0 → tx registers reload the previous hold values (repeat last sample) and `underrun` pulses in the cycle p=0.
- **frame_start:** high exactly in cycles where p=0.
- **Reset:**
  - p=0.
  - All holding and tx registers = 0; pending = 0.
  - All outputs = 0: bclk, lrclk and sdata low, no pulses.
  - The first frame after reset release transmits zeros and raises no underrun.
  - Reset asserted mid-frame aborts the frame immediately with no partial-word recovery.

## Timing
- Each output reflects the p value in the same cycle (counter and outputs are updated by the same edge).
- **Latency:** a sample accepted at any p ≤ last position appears on SDATA (MSB) at p = BCLK_DIV (left) and p = 32·BCLK_DIV + BCLK_DIV (right) of the next frame.
- Worst-case latency is one frame plus BCLK_DIV cycles.
- The intended upstream pattern is one `sample_valid` per `frame_start`, at any offset.
- `sample_valid` in the cycle p=0 lands in holding for the following frame.
- `overrun` and `underrun` are mutually exclusive in any given cycle.
- At defaults:
  - BCLK period is 4 clk (3.18 MHz).
  - LRCLK is low for p 0..127 and high for p 128..255.

## Test plan
- **Reset:** assert reset mid-frame → all outputs 0 asynchronously. After release, p restarts, `frame_start` appears at cycle 0 and then every 256 cycles, and the first frame's SDATA is all zeros.
- **Serialization:** drive `sample_valid` at p=100 with L=0x800001, R=0x7FFFFE. In the next frame:
  - SDATA during left slots 1..24 = 1,0…0,1;
  - right slots 1..24 = 0,1…1,0;
  - slots 0 and 25..31 = 0.
  - Check each bit on BCLK rising edges.
- **Underrun:** send one sample and then none → `underrun` pulses at p=0 of the following frame, and the same L/R words are retransmitted.
- **Overrun:** two `sample_valid` strobes (0x111111 then 0x222222) in one frame → `overrun` pulse on the second strobe, and the next frame transmits 0x222222.
- **Boundary bypass:** `sample_valid` at p=255 with 0x0ABCDE and pending=0 → transmitted in the immediately following frame, with no overrun and no underrun.
- **Parameter sweep:** BCLK_DIV=2, DAC_OUTPUT_WIDTH=16 → frame is 128 clk, BCLK period is 2 clk, and 16 data bits appear in slots 1..16.
